// File: rtl/aes_stream_ctrl.sv
// Streaming AES controller: builds and caches the round-key schedule once per key load,
// then sequences external key-step and round engines for each enc/dec block.
module aes_stream_ctrl #(
  parameter int NR          = 10,
  parameter int RC_W        = 4,
  parameter int RND_TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            key_load,
  input  logic [127:0]    key_in,
  output logic            key_ld_rdy,
  output logic            key_valid,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_enc,
  input  logic [127:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic            out_enc,
  output logic            err_tmo,
  output logic            ks_en,
  output logic [RC_W-1:0] ks_rc,
  output logic [127:0]    ks_prev,
  input  logic [127:0]    ks_next,
  output logic            rd_en,
  output logic            rd_enc,
  output logic [RC_W-1:0] rd_idx,
  output logic [127:0]    rd_key,
  output logic [127:0]    rd_din,
  input  logic [127:0]    rd_dout,
  input  logic            rd_rdy
);
  localparam int CW = $clog2(RND_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_KEYGEN, S_READY, S_ROUND, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [NR:0][127:0]     rk_q, rk_d;
  logic [RC_W-1:0]        kidx_q, kidx_d;
  logic                   kph_q, kph_d;
  logic                   key_valid_q, key_valid_d;
  logic [RC_W-1:0]        r_q, r_d;
  logic [127:0]           st_q, st_d;
  logic                   mode_q, mode_d;
  logic                   start_q, start_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [127:0]           out_data_q, out_data_d;
  logic                   err_tmo_q, err_tmo_d;
  logic [RC_W-1:0]        rk_sel;

  wire in_round = (state_q == S_ROUND);
  wire in_kgen  = (state_q == S_KEYGEN);

  // Decrypt walks the cached schedule backwards.
  assign rk_sel     = mode_q ? r_q : RC_W'(NR) - r_q;

  assign key_ld_rdy = (state_q == S_IDLE) || (state_q == S_READY);
  assign key_valid  = key_valid_q;
  assign in_ready   = (state_q == S_READY) && key_valid_q && !key_load;
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = out_data_q;
  assign out_enc    = out_valid && mode_q;
  assign err_tmo    = err_tmo_q;
  assign ks_en      = in_kgen && !kph_q;
  assign ks_rc      = in_kgen ? kidx_q : '0;
  assign ks_prev    = in_kgen ? rk_q[kidx_q - 1'b1] : '0;
  assign rd_en      = in_round && start_q;
  assign rd_enc     = in_round && mode_q;
  assign rd_idx     = in_round ? r_q : '0;
  assign rd_key     = in_round ? rk_q[rk_sel] : '0;
  assign rd_din     = in_round ? st_q : '0;

  always_comb begin
    state_d     = state_q;
    rk_d        = rk_q;
    kidx_d      = kidx_q;
    kph_d       = kph_q;
    key_valid_d = key_valid_q;
    r_d         = r_q;
    st_d        = st_q;
    mode_d      = mode_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    err_tmo_d   = err_tmo_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (key_load) begin
          rk_d[0]     = key_in;
          err_tmo_d   = 1'b0;
          key_valid_d = 1'b0;
          kidx_d      = RC_W'(1);
          kph_d       = 1'b0;
          state_d     = S_KEYGEN;
        end else if (in_valid && in_ready) begin
          mode_d  = in_enc;
          st_d    = in_data ^ (in_enc ? rk_q[0] : rk_q[NR]);
          r_d     = RC_W'(1);
          start_d = 1'b1;
          state_d = S_ROUND;
        end
      end
      S_KEYGEN: begin
        // Even phase drives the step engine, odd phase captures its result.
        if (!kph_q) begin
          kph_d = 1'b1;
        end else begin
          rk_d[kidx_q] = ks_next;
          kph_d        = 1'b0;
          if (kidx_q == RC_W'(NR)) begin
            key_valid_d = 1'b1;
            state_d     = S_READY;
          end else begin
            kidx_d = kidx_q + 1'b1;
          end
        end
      end
      S_ROUND: begin
        if (start_q) begin
          start_d = 1'b0;
          cnt_d   = CW'(1);
        end else if (rd_rdy) begin
          if (r_q == RC_W'(NR)) begin
            out_data_d = rd_dout;
            state_d    = S_OUT;
          end else begin
            st_d    = rd_dout;
            r_d     = r_q + 1'b1;
            start_d = 1'b1;
          end
        end else if (cnt_q == CW'(RND_TIMEOUT)) begin
          err_tmo_d = 1'b1;
          state_d   = S_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: if (out_ready) state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      kidx_q      <= '0;
      kph_q       <= 1'b0;
      key_valid_q <= 1'b0;
      r_q         <= '0;
      st_q        <= '0;
      mode_q      <= 1'b0;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kidx_q      <= kidx_d;
      kph_q       <= kph_d;
      key_valid_q <= key_valid_d;
      r_q         <= r_d;
      st_q        <= st_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  // Schedule storage is only meaningful once key_valid is set, so it needs no reset.
  always_ff @(posedge CLK) rk_q <= rk_d;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with behavioural AES-128 key-step and round engines.
module tb_aes_stream_ctrl;
  localparam int NR = 10, RC_W = 4, RND_TIMEOUT = 64;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic CLK = 1'b0, RST = 1'b1;
  always #5 CLK = ~CLK;

  logic            key_load = 0, key_ld_rdy, key_valid;
  logic [127:0]    key_in = '0;
  logic            in_valid = 0, in_ready, in_enc = 0;
  logic [127:0]    in_data = '0;
  logic            out_valid, out_ready = 0, out_enc, err_tmo;
  logic [127:0]    out_data;
  logic            ks_en, rd_en, rd_enc;
  logic [RC_W-1:0] ks_rc, rd_idx;
  logic [127:0]    ks_prev, ks_next = '0, rd_key, rd_din, rd_dout = '0;
  logic            rd_rdy = 0;

  aes_stream_ctrl #(.NR(NR), .RC_W(RC_W), .RND_TIMEOUT(RND_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .key_load(key_load), .key_in(key_in), .key_ld_rdy(key_ld_rdy),
    .key_valid(key_valid), .in_valid(in_valid), .in_ready(in_ready), .in_enc(in_enc),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_enc(out_enc), .err_tmo(err_tmo), .ks_en(ks_en), .ks_rc(ks_rc), .ks_prev(ks_prev),
    .ks_next(ks_next), .rd_en(rd_en), .rd_enc(rd_enc), .rd_idx(rd_idx), .rd_key(rd_key),
    .rd_din(rd_din), .rd_dout(rd_dout), .rd_rdy(rd_rdy));

  int ntests = 0, nfail = 0;
  logic [7:0] sb [256];
  logic [7:0] isb[256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] ks_step(input logic [127:0] p, input logic [RC_W-1:0] rc);
    logic [7:0]  rcon;
    logic [31:0] w3, t, n0, n1, n2, n3;
    rcon = 8'h01;
    for (int i = 1; i < int'(rc); i++) rcon = xt(rcon);
    w3 = p[31:0];
    t  = {sb[w3[23:16]] ^ rcon, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
    n0 = p[127:96] ^ t;
    n1 = p[95:64] ^ n0;
    n2 = p[63:32] ^ n1;
    n3 = p[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic enc, input logic last);
    logic [7:0] b[16], u[16], v[16], cf[4];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        u[4*c+rw] = enc ? sb[b[4*((c+rw)%4)+rw]] : isb[b[4*((c-rw+4)%4)+rw]];
    if (!enc) for (int i = 0; i < 16; i++) u[i] = u[i] ^ k[127-8*i -: 8];
    if (enc) begin cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1; end
    else     begin cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9; end
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        v[4*c+rw] = 8'h00;
        for (int j = 0; j < 4; j++) v[4*c+rw] = v[4*c+rw] ^ gm(u[4*c+j], cf[(j-rw+4)%4]);
      end
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = last ? u[i] : v[i];
      if (enc) r[127-8*i -: 8] = r[127-8*i -: 8] ^ k[127-8*i -: 8];
    end
    return r;
  endfunction

  // Key-step engine: result valid the cycle after ks_en.
  always @(posedge CLK) if (ks_en === 1'b1) ks_next <= ks_step(ks_prev, ks_rc);

  int ks_cnt = 0;
  always @(posedge CLK) if (ks_en === 1'b1) ks_cnt <= ks_cnt + 1;

  // Round engine with fixed latency; 'withhold' suppresses the done pulse.
  logic         rb_busy = 0, withhold = 0;
  int           rb_cd = 0;
  logic [127:0] rb_res = '0;
  always @(posedge CLK) begin
    rd_rdy <= 1'b0;
    if (rd_en === 1'b1) begin
      rb_busy <= 1'b1;
      rb_cd   <= 2;
      rb_res  <= aes_round(rd_din, rd_key, rd_enc, rd_idx == RC_W'(NR));
    end else if (rb_busy) begin
      if (rb_cd == 0) begin
        rb_busy <= 1'b0;
        if (!withhold) begin
          rd_rdy  <= 1'b1;
          rd_dout <= rb_res;
        end
      end else rb_cd <= rb_cd - 1;
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_load = 1'b1; step(); key_load = 1'b0;
  endtask

  task automatic wait_kv(input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk(tag, key_valid, 1);
  endtask

  task automatic send(input string tag, input logic [127:0] d, input logic e);
    int n = 0;
    in_data = d; in_enc = e; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
    chk(tag, in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 2000) begin step(); n++; end
    chk(tag, out_valid, 1);
  endtask

  task automatic take();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, {key_ld_rdy, key_valid, in_ready, out_valid, out_enc, err_tmo, ks_en, rd_en},
        8'b1000_0000);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_rdkey"}, rd_key | rd_din | ks_prev, '0);
  endtask

  initial begin
    int n, k0, bad, saw;
    logic [7:0] inv, x;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b2 = 1; b2 < 256; b2++) if (gm(8'(a), 8'(b2)) == 8'h01) inv = 8'(b2);
      x = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[a]  = x;
      isb[x] = 8'(a);
    end

    repeat (3) step();
    chk_reset("reset");
    RST = 1'b0;
    step();

    // 1: key build then encrypt
    k0 = ks_cnt;
    load_key(K);
    chk("kgen_busy", {key_ld_rdy, key_valid}, 2'b00);
    wait_kv("t1_keyvalid");
    chk("t1_kssteps", 32'(ks_cnt - k0), 32'd10);
    send("t1_accept", PT, 1'b1);
    chk("t1_inready_low", in_ready, 0);
    wait_out("t1_outvalid");
    chk("t1_data", out_data, CT);
    chk("t1_enc", out_enc, 1);
    take();

    // 2: decrypt with cached schedule
    k0 = ks_cnt;
    send("t2_accept", CT, 1'b0);
    wait_out("t2_outvalid");
    chk("t2_data", out_data, PT);
    chk("t2_enc", out_enc, 0);
    chk("t2_no_kgen", 32'(ks_cnt - k0), 32'd0);
    take();

    // 3: four blocks, out_ready held off for five cycles each
    for (int i = 0; i < 4; i++) begin
      send("t3_accept", (i % 2 == 0) ? PT : CT, (i % 2 == 0));
      wait_out("t3_outvalid");
      for (int j = 0; j < 5; j++) begin
        chk("t3_inready_out", {in_ready, out_valid}, 2'b01);
        step();
      end
      chk("t3_data", out_data, (i % 2 == 0) ? CT : PT);
      chk("t3_enc", out_enc, (i % 2 == 0) ? 1 : 0);
      take();
    end

    // 4: key_load mid-block is ignored
    k0 = ks_cnt; bad = 0;
    send("t4_accept", PT, 1'b1);
    repeat (8) begin if (key_ld_rdy !== 1'b0) bad++; step(); end
    load_key(128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
    n = 0;
    while (out_valid !== 1'b1 && n < 2000) begin
      if (key_ld_rdy !== 1'b0) bad++;
      step(); n++;
    end
    chk("t4_outvalid", out_valid, 1);
    chk("t4_keyldrdy_low", 32'(bad), 32'd0);
    chk("t4_data", out_data, CT);
    chk("t4_keep_key", {key_valid, 32'(ks_cnt - k0)}, {1'b1, 32'd0});
    take();

    // 5: round engine stalls -> timeout, then recovery
    withhold = 1'b1; saw = 0; n = 0;
    send("t5_accept", PT, 1'b1);
    while (err_tmo !== 1'b1 && n < 300) begin
      if (out_valid === 1'b1) saw++;
      step(); n++;
    end
    chk("t5_err", err_tmo, 1);
    chk("t5_window", (n >= RND_TIMEOUT) && (n <= RND_TIMEOUT + 4), 1);
    chk("t5_no_out", {32'(saw), out_valid}, {32'd0, 1'b0});
    chk("t5_inready", in_ready, 1);
    withhold = 1'b0;
    send("t5_accept2", CT, 1'b0);
    wait_out("t5_outvalid");
    chk("t5_data", out_data, PT);
    chk("t5_err_sticky", err_tmo, 1);
    take();
    load_key(K);
    chk("t5_err_clr", {err_tmo, key_valid}, 2'b00);
    wait_kv("t5_keyvalid");

    // 6: reset in KEYGEN step 5 and in round 3
    load_key(K);
    n = 0;
    while (!(ks_en === 1'b1 && ks_rc == 4'd5) && n < 100) begin step(); n++; end
    chk("t6_ks5", {ks_en, ks_rc}, {1'b1, 4'd5});
    RST = 1'b1; step();
    chk_reset("t6_rst_kgen");
    RST = 1'b0; step();
    chk("t6_kv_low", {key_valid, key_ld_rdy}, 2'b01);
    load_key(K);
    wait_kv("t6_keyvalid");
    send("t6_accept", PT, 1'b1);
    n = 0;
    while (!(rd_en === 1'b1 && rd_idx == 4'd3) && n < 200) begin step(); n++; end
    chk("t6_rd3", {rd_en, rd_idx}, {1'b1, 4'd3});
    RST = 1'b1; step();
    chk_reset("t6_rst_round");
    RST = 1'b0; saw = 0;
    repeat (40) begin if (out_valid !== 1'b0) saw++; step(); end
    chk("t6_no_out", {32'(saw), key_valid}, {32'd0, 1'b0});
    load_key(K);
    wait_kv("t6_keyvalid2");
    send("t6_accept2", PT, 1'b1);
    wait_out("t6_outvalid");
    chk("t6_data", out_data, CT);
    take();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
